run_sequencer: RTL
==================

# run_sequencer

Host-side initiator for the core's `req`/`done` run handshake. It runs NPROG programs back to back. Each run is a core reset pulse, a one-cycle `req` and a wait for `done`, and each run's cycle count is reported on a one-cycle result strobe. It sits between the bench or host logic and the core top level, driving the core's `reset` and `req` and observing its `done`.

## Interface
Parameters:
- NPROG, 3: number of programs run per `start`. Must be ≥1.
- CW, 16: width of the cycle counter and the reported count.
- RST_CYCLES, 2: cycles `core_reset` is held high before each run. Must be ≥1.
- TIMEOUT, 1000: run-cycle limit, used only when RUN_TIMEOUT_EN is defined. Must be ≥1 and < 2^CW.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a sequence. Sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- all_done  out  1  one-cycle pulse after the last program's report.
- core_reset  out  1  drives the core's `reset`. Equals `reset` OR (state==RST).
- core_req  out  1  drives the core's `req`. High only in REQ.
- core_done  in  1  the core's `done`. May be combinational and may glitch, so it is registered internally.
- rpt_valid  out  1  one-cycle result strobe.
- rpt_prog  out  2  index of the program being reported, 0..NPROG-1.
- rpt_cycles  out  CW  RUN-state cycle count for the reported program.
- rpt_timeout  out  1  the reported run ended by timeout rather than by `done`.

## Operation
- `core_done` is registered into `done_q` every cycle. All decisions use `done_q`.
- States and transitions:
  - IDLE: `start`=1 → RST, with prog=0 and rst_cnt=0.
  - RST: `core_reset`=1 and rst_cnt increments each cycle. When rst_cnt==RST_CYCLES-1 → REQ.
  - REQ: `core_req`=1 for exactly one cycle and cyc_cnt is cleared to 0. Next state is RUN.
  - RUN: cyc_cnt increments each cycle and saturates at 2^CW-1. If `done_q`=1 → REPORT with rpt_timeout=0. Otherwise, with the macro defined, if cyc_cnt==TIMEOUT-1 → REPORT with rpt_timeout=1.
  - REPORT: `rpt_valid`=1, `rpt_prog`=prog, `rpt_cycles`=cyc_cnt. If prog<NPROG-1, prog increments and the next state is RST (rst_cnt=0). Otherwise the next state is IDLE and `all_done` pulses in the same cycle.
- `done_q` is ignored in IDLE, RST and REQ. A stale `done` left over from the previous program is masked by the core reset and by that ignore window.
- If `done_q`=1 and the timeout threshold are reached in the same cycle, `done` wins and rpt_timeout=0.
- `start` while busy is ignored. `start` held high through the return to IDLE begins a new sequence on the next cycle.
- rpt_* hold their last values between strobes. Consumers qualify them with `rpt_valid` only.
- Reset mid-operation, in any state, goes to IDLE immediately. The sequence is abandoned and no report is issued.

## Timing
- Reset values: state=IDLE, busy=0, all_done=0, core_req=0, rpt_valid=0, rpt_prog=0, rpt_cycles=0, rpt_timeout=0, prog=0, cyc_cnt=0, done_q=0. `core_reset`=1 while `reset` is high.
- Latencies:
  - `start` at edge n: `core_reset` high for cycles n+1..n+RST_CYCLES, and `core_req` high in cycle n+RST_CYCLES+1.
  - `core_done` rising in RUN cycle k: `done_q` is seen at k+1 and `rpt_valid` is high at k+2.
- `rpt_cycles` counts RUN cycles, including the cycle in which `done_q` was seen. A core raising `done` in its first cycle after `req` reports 2.
- Per-program overhead between runs is RST_CYCLES + 2 cycles (RST, REQ, REPORT).

## Configuration
- `RUN_TIMEOUT_EN` defined:
  - The RUN-state watchdog is compiled in.
  - A run lasting TIMEOUT cycles without `done` reports rpt_timeout=1 and rpt_cycles=TIMEOUT-1, then the sequence continues with the next program.
- `RUN_TIMEOUT_EN` undefined:
  - No watchdog; RUN waits indefinitely, saturating cyc_cnt.
  - `rpt_timeout` is tied to 0 and TIMEOUT is unused.

## Test plan
- **Nominal sequence.** NPROG=3, RST_CYCLES=2. Model core raises `done` 5, 9 and 1 cycles after `req`. Expect three `rpt_valid` strobes with rpt_prog 0/1/2 and rpt_cycles 6/10/2. `all_done` pulses together with the third strobe, and busy=0 on the next cycle.
- **Handshake shape.** Expect `core_reset` high for exactly 2 cycles, then `core_req` high for exactly 1 cycle, before each program. Check `core_req` never overlaps `core_reset`.
- **Stale and glitchy `done`.**
  - Model holds `done`=1 until reset: the next program's RUN does not finish before its own `done`.
  - A one-cycle `done` glitch during RST is ignored.
- **Timeout (macro defined, TIMEOUT=20).** Core never asserts `done`. Expect each report with rpt_timeout=1 and rpt_cycles=19, then the next program starts.
- **Simultaneous `done` and timeout.** `done_q` rises in the same cycle cyc_cnt reaches TIMEOUT-1. Expect rpt_timeout=0.
- **Reset and start edge cases.**
  - Assert `reset` in RUN of program 1: busy falls immediately, with no `rpt_valid` and no `all_done`.
  - `start` pulsed while busy has no effect.

Source files
------------

// File: rtl/run_sequencer.sv
// Host-side run sequencer: per program it pulses core reset, issues a one-cycle req, waits for done
// and reports the run length. Define RUN_TIMEOUT_EN to compile in the RUN-state watchdog.
module run_sequencer #(
   parameter int NPROG      = 3,
   parameter int CW         = 16,
   parameter int RST_CYCLES = 2,
   parameter int TIMEOUT    = 1000
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic          busy,
   output logic          all_done,
   output logic          core_reset,
   output logic          core_req,
   input  logic          core_done,
   output logic          rpt_valid,
   output logic [1:0]    rpt_prog,
   output logic [CW-1:0] rpt_cycles,
   output logic          rpt_timeout
);

   localparam int            RW        = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
   localparam logic [1:0]    PROG_LAST = 2'(NPROG - 1);
   localparam logic [CW-1:0] CYC_MAX   = {CW{1'b1}};
   localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT - 1);
`ifdef RUN_TIMEOUT_EN
   localparam logic          TMO_EN    = 1'b1;
`else
   localparam logic          TMO_EN    = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RST    = 3'd1,
      S_REQ    = 3'd2,
      S_RUN    = 3'd3,
      S_REPORT = 3'd4
   } state_t;

   state_t        state_r;
   state_t        state_s;
   logic [1:0]    prog_r;
   logic [1:0]    prog_s;
   logic [RW-1:0] rst_cnt_r;
   logic [RW-1:0] rst_cnt_s;
   logic [CW-1:0] cyc_cnt_r;
   logic [CW-1:0] cyc_cnt_s;
   logic [CW-1:0] cyc_inc_s;
   logic          done_q_r;
   logic          rst_phase_r;
   logic          tmo_hit_s;
   logic          rpt_load_s;
   logic          all_done_s;

   // Core reset must follow the async reset without waiting for a clock edge.
   assign core_reset = reset | rst_phase_r;

   // Next-state, counter and report-load decode.
   always_comb begin
      state_s    = state_r;
      prog_s     = prog_r;
      rst_cnt_s  = rst_cnt_r;
      cyc_cnt_s  = cyc_cnt_r;
      rpt_load_s = 1'b0;
      all_done_s = 1'b0;
      cyc_inc_s  = (cyc_cnt_r == CYC_MAX) ? cyc_cnt_r : cyc_cnt_r + CW'(1);
      tmo_hit_s  = TMO_EN & (cyc_cnt_r == TMO_LAST);
      case (state_r)
         S_IDLE: begin
            if (start) begin
               state_s   = S_RST;
               prog_s    = 2'd0;
               rst_cnt_s = RW'(0);
            end else begin
               state_s = S_IDLE;
            end
         end
         S_RST: begin
            rst_cnt_s = rst_cnt_r + RW'(1);
            if (rst_cnt_r == RST_LAST) begin
               state_s = S_REQ;
            end else begin
               state_s = S_RST;
            end
         end
         S_REQ: begin
            cyc_cnt_s = {CW{1'b0}};
            state_s   = S_RUN;
         end
         S_RUN: begin
            // done beats the watchdog; on timeout the count freezes at TIMEOUT-1
            if (done_q_r) begin
               cyc_cnt_s  = cyc_inc_s;
               rpt_load_s = 1'b1;
               state_s    = S_REPORT;
            end else if (tmo_hit_s) begin
               cyc_cnt_s  = cyc_cnt_r;
               rpt_load_s = 1'b1;
               state_s    = S_REPORT;
            end else begin
               cyc_cnt_s = cyc_inc_s;
               state_s   = S_RUN;
            end
            all_done_s = rpt_load_s & (prog_r == PROG_LAST);
         end
         S_REPORT: begin
            if (prog_r == PROG_LAST) begin
               state_s = S_IDLE;
            end else begin
               prog_s    = prog_r + 2'd1;
               rst_cnt_s = RW'(0);
               state_s   = S_RST;
            end
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase
   end

   // State, counters, input sampling and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= S_IDLE;
         prog_r      <= 2'd0;
         rst_cnt_r   <= RW'(0);
         cyc_cnt_r   <= {CW{1'b0}};
         done_q_r    <= 1'b0;
         rst_phase_r <= 1'b0;
         busy        <= 1'b0;
         all_done    <= 1'b0;
         core_req    <= 1'b0;
         rpt_valid   <= 1'b0;
         rpt_prog    <= 2'd0;
         rpt_cycles  <= {CW{1'b0}};
`ifdef RUN_TIMEOUT_EN
         rpt_timeout <= 1'b0;
`endif
      end else begin
         state_r     <= state_s;
         prog_r      <= prog_s;
         rst_cnt_r   <= rst_cnt_s;
         cyc_cnt_r   <= cyc_cnt_s;
         done_q_r    <= core_done;
         rst_phase_r <= (state_s == S_RST);
         busy        <= (state_s != S_IDLE);
         all_done    <= all_done_s;
         core_req    <= (state_s == S_REQ);
         rpt_valid   <= rpt_load_s;
         if (rpt_load_s) begin
            rpt_prog    <= prog_r;
            rpt_cycles  <= cyc_cnt_s;
`ifdef RUN_TIMEOUT_EN
            rpt_timeout <= ~done_q_r;
`endif
         end
      end
   end

`ifndef RUN_TIMEOUT_EN
   assign rpt_timeout = 1'b0;
`endif

endmodule
